// File: rtl/apb_master_requester_if.sv
// Command/response and APB bus bundle for apb_master_requester.
// master: the requester's view (drives CMD_READY, RSP_* and the APB request).
// slave:  the opposite side (command source plus APB completer).
interface apb_master_requester_if;
  logic        CMD_VALID;
  logic        CMD_READY;
  logic        CMD_WRITE;
  logic [31:0] CMD_ADDR;
  logic [31:0] CMD_WDATA;
  logic        RSP_VALID;
  logic [31:0] RSP_RDATA;
  logic        RSP_ERR;
  logic        RSP_TIMEOUT;
  logic        PSELx;
  logic        PENABLE;
  logic        PWRITE;
  logic [31:0] PADDR;
  logic [31:0] PWDATA;
  logic [31:0] PRDATA;
  logic        PREADY;
  logic        PSLVERR;

  modport master (
    input  CMD_VALID, CMD_WRITE, CMD_ADDR, CMD_WDATA, PRDATA, PREADY, PSLVERR,
    output CMD_READY, RSP_VALID, RSP_RDATA, RSP_ERR, RSP_TIMEOUT,
           PSELx, PENABLE, PWRITE, PADDR, PWDATA
  );

  modport slave (
    output CMD_VALID, CMD_WRITE, CMD_ADDR, CMD_WDATA, PRDATA, PREADY, PSLVERR,
    input  CMD_READY, RSP_VALID, RSP_RDATA, RSP_ERR, RSP_TIMEOUT,
           PSELx, PENABLE, PWRITE, PADDR, PWDATA
  );
endinterface

// File: rtl/apb_master_requester.sv
// APB requester: single read/write commands become SETUP + ACCESS transfers,
// completion is reported on a one-cycle RSP_VALID strobe.
// Optional feature macro: APB_MASTER_TIMEOUT_EN -- aborts an ACCESS phase that
// sees PREADY low for TIMEOUT_CYCLES wait cycles.
module apb_master_requester #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                          PCLK,
  input  logic                          PRESET,
  apb_master_requester_if.master        bus
);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

  state_t      state_q, state_d;
  logic        pwrite_q, pwrite_d;
  logic [31:0] paddr_q, paddr_d;
  logic [31:0] pwdata_q, pwdata_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;
  logic        timeout_hit;

`ifdef APB_MASTER_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] wait_q, wait_d;
  logic          to_q, to_d;

  // Wait counter: cleared in SETUP so it starts at 0 on ACCESS entry,
  // counts every PREADY-low ACCESS cycle.
  always_comb begin
    wait_d = wait_q;
    if (state_q == SETUP)
      wait_d = '0;
    else if (state_q == ACCESS && !bus.PREADY)
      wait_d = wait_q + CW'(1);
  end

  // Wait counter register.
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) wait_q <= '0;
    else        wait_q <= wait_d;
  end

  // PREADY high in the limit cycle takes priority, hence the !PREADY term.
  assign timeout_hit = (state_q == ACCESS) && !bus.PREADY &&
                       (wait_q == CW'(TIMEOUT_CYCLES));

  // Timeout flag only changes on a completion and is held otherwise.
  assign to_d = rsp_valid_d ? timeout_hit : to_q;

  // Timeout status register.
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) to_q <= 1'b0;
    else        to_q <= to_d;
  end

  assign bus.RSP_TIMEOUT = to_q;
`else
  localparam bit unused_timeout_cfg = (TIMEOUT_CYCLES > 0);

  assign timeout_hit     = 1'b0;
  assign bus.RSP_TIMEOUT = 1'b0;
`endif

  // Next-state, request capture and response capture.
  always_comb begin
    state_d     = state_q;
    pwrite_d    = pwrite_q;
    paddr_d     = paddr_q;
    pwdata_d    = pwdata_q;
    rsp_valid_d = 1'b0;
    rdata_d     = rdata_q;
    err_d       = err_q;
    unique case (state_q)
      IDLE: begin
        if (bus.CMD_VALID) begin
          pwrite_d = bus.CMD_WRITE;
          paddr_d  = bus.CMD_ADDR;
          pwdata_d = bus.CMD_WDATA;
          state_d  = SETUP;
        end
      end
      SETUP: state_d = ACCESS;
      ACCESS: begin
        if (bus.PREADY) begin
          rsp_valid_d = 1'b1;
          rdata_d     = pwrite_q ? 32'h0 : bus.PRDATA;
          err_d       = bus.PSLVERR;
          state_d     = IDLE;
        end else if (timeout_hit) begin
          rsp_valid_d = 1'b1;
          rdata_d     = 32'h0;
          err_d       = 1'b1;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      state_q     <= IDLE;
      pwrite_q    <= 1'b0;
      paddr_q     <= 32'h0;
      pwdata_q    <= 32'h0;
      rsp_valid_q <= 1'b0;
      rdata_q     <= 32'h0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      pwrite_q    <= pwrite_d;
      paddr_q     <= paddr_d;
      pwdata_q    <= pwdata_d;
      rsp_valid_q <= rsp_valid_d;
      rdata_q     <= rdata_d;
      err_q       <= err_d;
    end
  end

  // Bus controls decode from state only, so reset clears them immediately.
  assign bus.CMD_READY = (state_q == IDLE);
  assign bus.PSELx     = (state_q != IDLE);
  assign bus.PENABLE   = (state_q == ACCESS);
  assign bus.PWRITE    = pwrite_q;
  assign bus.PADDR     = paddr_q;
  assign bus.PWDATA    = pwdata_q;
  assign bus.RSP_VALID = rsp_valid_q;
  assign bus.RSP_RDATA = rdata_q;
  assign bus.RSP_ERR   = err_q;

endmodule

// File: tb/tb_apb_master_requester.sv
// Bench for apb_master_requester: directed cases plus random transfers
// against a transfer-level model (latency = 3 + waits, response rules).
module tb_apb_master_requester;
  localparam int TO = 4;
`ifdef APB_MASTER_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic PCLK   = 1'b0;
  logic PRESET = 1'b1;

  apb_master_requester_if bus();

  apb_master_requester #(.TIMEOUT_CYCLES(TO)) dut (
    .PCLK  (PCLK),
    .PRESET(PRESET),
    .bus   (bus)
  );

  always #5 PCLK = ~PCLK;

  int n_chk  = 0;
  int n_pass = 0;

  // Model of the last completed response and last issued request.
  logic [31:0] m_rdata = 32'h0;
  logic        m_err   = 1'b0;
  logic        m_to    = 1'b0;
  logic [31:0] m_addr  = 32'h0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h", tag, got, exp);
  endtask

  // Called at a negedge; returns at the negedge of the response cycle.
  task automatic xfer(input bit wr, input logic [31:0] addr, input logic [31:0] wdata,
                      input int waits, input logic [31:0] rd, input bit err,
                      input bit junk_err, input bit hold);
    bit abort;
    int last;
    abort = TO_EN && (waits > TO);
    last  = abort ? TO : waits;
    bus.CMD_VALID = 1'b1;
    bus.CMD_WRITE = wr;
    bus.CMD_ADDR  = addr;
    bus.CMD_WDATA = wdata;
    chk("ready_idle", 32'(bus.CMD_READY), 1);
    @(posedge PCLK);
    @(negedge PCLK);
    if (hold) begin
      bus.CMD_WRITE = ~wr;
      bus.CMD_ADDR  = $urandom;
      bus.CMD_WDATA = $urandom;
    end else begin
      bus.CMD_VALID = 1'b0;
    end
    chk("setup_psel", 32'(bus.PSELx), 1);
    chk("setup_pen", 32'(bus.PENABLE), 0);
    chk("setup_ready", 32'(bus.CMD_READY), 0);
    chk("setup_paddr", bus.PADDR, addr);
    chk("setup_pwrite", 32'(bus.PWRITE), 32'(wr));
    chk("setup_pwdata", bus.PWDATA, wdata);
    bus.PREADY  = 1'b0;
    bus.PSLVERR = junk_err;
    bus.PRDATA  = $urandom;
    @(posedge PCLK);
    for (int k = 0; k <= last; k++) begin
      @(negedge PCLK);
      chk("acc_psel", 32'(bus.PSELx), 1);
      chk("acc_pen", 32'(bus.PENABLE), 1);
      chk("acc_paddr", bus.PADDR, addr);
      chk("acc_pwdata", bus.PWDATA, wdata);
      chk("acc_pwrite", 32'(bus.PWRITE), 32'(wr));
      chk("acc_ready", 32'(bus.CMD_READY), 0);
      chk("acc_rspv", 32'(bus.RSP_VALID), 0);
      if (k == last && !abort) begin
        bus.PREADY  = 1'b1;
        bus.PRDATA  = rd;
        bus.PSLVERR = err;
      end else begin
        bus.PREADY  = 1'b0;
        bus.PRDATA  = $urandom;
        bus.PSLVERR = junk_err;
      end
      @(posedge PCLK);
    end
    @(negedge PCLK);
    bus.CMD_VALID = 1'b0;
    bus.PREADY    = 1'b0;
    bus.PSLVERR   = 1'b0;
    m_rdata = (abort || wr) ? 32'h0 : rd;
    m_err   = abort ? 1'b1 : err;
    m_to    = abort;
    m_addr  = addr;
    chk("rsp_valid", 32'(bus.RSP_VALID), 1);
    chk("rsp_rdata", bus.RSP_RDATA, m_rdata);
    chk("rsp_err", 32'(bus.RSP_ERR), 32'(m_err));
    chk("rsp_to", 32'(bus.RSP_TIMEOUT), 32'(m_to));
    chk("rsp_psel", 32'(bus.PSELx), 0);
    chk("rsp_pen", 32'(bus.PENABLE), 0);
    chk("rsp_ready", 32'(bus.CMD_READY), 1);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge PCLK);
      @(negedge PCLK);
      chk("idle_rspv", 32'(bus.RSP_VALID), 0);
      chk("idle_rdata", bus.RSP_RDATA, m_rdata);
      chk("idle_err", 32'(bus.RSP_ERR), 32'(m_err));
      chk("idle_to", 32'(bus.RSP_TIMEOUT), 32'(m_to));
      chk("idle_psel", 32'(bus.PSELx), 0);
      chk("idle_ready", 32'(bus.CMD_READY), 1);
      chk("idle_paddr", bus.PADDR, m_addr);
    end
  endtask

  task automatic reset_checks(input string tag);
    chk({tag, "_psel"}, 32'(bus.PSELx), 0);
    chk({tag, "_pen"}, 32'(bus.PENABLE), 0);
    chk({tag, "_pwrite"}, 32'(bus.PWRITE), 0);
    chk({tag, "_paddr"}, bus.PADDR, 0);
    chk({tag, "_pwdata"}, bus.PWDATA, 0);
    chk({tag, "_rspv"}, 32'(bus.RSP_VALID), 0);
    chk({tag, "_rdata"}, bus.RSP_RDATA, 0);
    chk({tag, "_err"}, 32'(bus.RSP_ERR), 0);
    chk({tag, "_to"}, 32'(bus.RSP_TIMEOUT), 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired got=running exp=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.CMD_VALID = 1'b0;
    bus.CMD_WRITE = 1'b0;
    bus.CMD_ADDR  = 32'h0;
    bus.CMD_WDATA = 32'h0;
    bus.PRDATA    = 32'h0;
    bus.PREADY    = 1'b0;
    bus.PSLVERR   = 1'b0;
    repeat (2) @(negedge PCLK);
    reset_checks("rst");
    PRESET = 1'b0;
    @(negedge PCLK);
    chk("rst_ready", 32'(bus.CMD_READY), 1);

    // Directed cases.
    xfer(1'b1, 32'h8, 32'h0000_1234, 0, 32'h0, 1'b0, 1'b0, 1'b0);
    idle(1);
    xfer(1'b0, 32'h4, 32'h0, 2, 32'hA5A5_0001, 1'b0, 1'b0, 1'b0);
    idle(1);
    xfer(1'b1, 32'h0, 32'hDEAD_BEEF, 0, 32'h0, 1'b1, 1'b0, 1'b0);
    idle(1);
    xfer(1'b0, 32'hC, 32'h0, 1, 32'h1357_9BDF, 1'b0, 1'b1, 1'b0);
    idle(1);
    // CMD_VALID held high across four back-to-back commands.
    for (int i = 0; i < 4; i++)
      xfer(i[0], 32'(i * 4), $urandom, 0, $urandom, 1'b0, 1'b0, 1'b1);
    idle(1);

`ifdef APB_MASTER_TIMEOUT_EN
    xfer(1'b0, 32'h4, 32'h0, 100, 32'hFFFF_FFFF, 1'b0, 1'b1, 1'b0);
    idle(1);
    xfer(1'b0, 32'h4, 32'h0, TO, 32'h0BAD_F00D, 1'b0, 1'b0, 1'b0);
    idle(1);
`endif

    // Random transfers.
    for (int i = 0; i < 40; i++) begin
      xfer(1'($urandom_range(0, 1)), 32'($urandom_range(0, 3) * 4), $urandom,
           int'($urandom_range(0, TO_EN ? 6 : 3)), $urandom,
           ($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 1)));
      idle(int'($urandom_range(0, 2)));
    end

    // Reset during an ACCESS wait.
    bus.CMD_VALID = 1'b1;
    bus.CMD_WRITE = 1'b1;
    bus.CMD_ADDR  = 32'hC;
    bus.CMD_WDATA = 32'h55;
    @(posedge PCLK);
    @(negedge PCLK);
    bus.CMD_VALID = 1'b0;
    @(posedge PCLK);
    @(negedge PCLK);
    chk("pre_rst_pen", 32'(bus.PENABLE), 1);
    @(posedge PCLK);
    #2;
    PRESET = 1'b1;
    #1;
    reset_checks("midrst");
    chk("midrst_ready", 32'(bus.CMD_READY), 1);
    @(negedge PCLK);
    PRESET = 1'b0;
    m_rdata = 32'h0;
    m_err   = 1'b0;
    m_to    = 1'b0;
    m_addr  = 32'h0;
    idle(3);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/apb_master_requester.md
# apb_master_requester

APB requester that drives the APB completer side of the APB-to-I2C bridge. It turns single read/write commands from a local command port into compliant two-phase APB transfers: SETUP, then ACCESS with wait states. It returns read data and the error status on a one-cycle response strobe. Typical use is as the CPU-side or testbench-side driver of the TX FIFO (0x0), RX FIFO (0x4), CONFIG (0x8) and TIMEOUT (0xC) registers.

## Interface
- TIMEOUT_CYCLES, 16: maximum ACCESS-phase wait cycles with PREADY low before abort. Only used with APB_MASTER_TIMEOUT_EN. Legal range 1..65535.
- Clock and reset: one clock; reset is asynchronous and active-high. The ports are PCLK and PRESET, following the codebase naming.
- PCLK  input  1  clock; all state updates on the rising edge.
- PRESET  input  1  asynchronous, active-high reset.
- CMD_VALID  input  1  a command is presented.
- CMD_READY  output  1  the command is accepted on the edge where VALID and READY are both high.
- CMD_WRITE  input  1  1 = write, 0 = read.
- CMD_ADDR  input  32  target address.
- CMD_WDATA  input  32  write data.
- RSP_VALID  output  1  one-cycle pulse that marks the end of a transfer.
- RSP_RDATA  output  32  read data; 0 for writes and for timeouts.
- RSP_ERR  output  1  PSLVERR sampled at completion, or 1 on timeout.
- RSP_TIMEOUT  output  1  1 when the transfer was aborted by timeout.
- PSELx  output  1  APB select.
- PENABLE  output  1  APB enable.
- PWRITE  output  1  APB direction.
- PADDR  output  32  APB address.
- PWDATA  output  32  APB write data.
- PRDATA  input  32  APB read data.
- PREADY  input  1  APB ready.
- PSLVERR  input  1  APB error.

## Operation
- The FSM has three states: IDLE, SETUP, ACCESS. The reset state is IDLE.
- CMD_READY = (state == IDLE). It is combinational from the state only, never from CMD_VALID.
- IDLE:
  - If CMD_VALID is high: register CMD_WRITE/ADDR/WDATA into PWRITE/PADDR/PWDATA and go to SETUP.
  - Otherwise stay in IDLE.
- SETUP: PSELx=1, PENABLE=0. Unconditionally go to ACCESS.
- ACCESS: PSELx=1, PENABLE=1.
  - If PREADY=1: capture RSP_RDATA (PRDATA for reads, 0 for writes) and RSP_ERR=PSLVERR, set RSP_VALID, go to IDLE.
  - If PREADY=0: stay in ACCESS.
- PADDR, PWRITE and PWDATA hold stable from SETUP through the final ACCESS cycle. They also hold their last value in IDLE; they are not zeroed.
- RSP_RDATA, RSP_ERR and RSP_TIMEOUT hold their values until the next completion.
- Reset values:
  - State IDLE; CMD_READY=1 once PRESET is released.
  - PSELx=0, PENABLE=0, PWRITE=0, PADDR=0, PWDATA=0.
  - RSP_VALID=0, RSP_RDATA=0, RSP_ERR=0, RSP_TIMEOUT=0.
- Reset asserted mid-transfer: all outputs go to their reset values immediately (asynchronously) and no response is produced. A command in flight is dropped.
- PSLVERR and PRDATA are ignored in every cycle except the completing ACCESS cycle.

## Timing
- Command accepted at edge N:
  - SETUP is visible in cycle N+1.
  - ACCESS is visible in cycle N+2.
  - With zero waits, PREADY is sampled high at edge N+3 and RSP_VALID is high in cycle N+3 for exactly one cycle.
- Each PREADY-low ACCESS cycle adds one cycle of latency.
- The next command can be accepted at the edge ending the RSP_VALID cycle, because the state is IDLE then. The minimum spacing is 3 cycles per transfer. PSELx is low for at least that one IDLE cycle.
- CMD_VALID while not in IDLE has no effect. The command port does not queue.

## Configuration
- APB_MASTER_TIMEOUT_EN defined:
  - A wait counter, $clog2(TIMEOUT_CYCLES+1) bits wide, clears on entry to ACCESS and increments on each ACCESS cycle with PREADY=0.
  - When the counter equals TIMEOUT_CYCLES and PREADY=0, the transfer aborts: go to IDLE and drop PSELx/PENABLE on the next cycle.
  - The abort pulses RSP_VALID with RSP_ERR=1, RSP_TIMEOUT=1 and RSP_RDATA=0.
  - PREADY=1 in that same cycle wins: the transfer completes normally.
- APB_MASTER_TIMEOUT_EN not defined: no counter exists, ACCESS waits indefinitely, and RSP_TIMEOUT is tied to 0.

## Test plan
- Write 0x0000_1234 to address 0x8 with PREADY tied high. Expect: SETUP one cycle with PSELx=1/PENABLE=0, ACCESS one cycle with PWDATA=0x1234, then RSP_VALID with RSP_ERR=0 and RSP_RDATA=0, 3 cycles after accept.
- Read 0x4 with PRDATA=0xA5A5_0001 and 2 wait cycles. Expect: ACCESS held 3 cycles with PADDR stable at 0x4, then RSP_RDATA=0xA5A5_0001 and RSP_VALID 5 cycles after accept.
- Write to 0x0 with PSLVERR=1 at completion. Expect RSP_ERR=1 and RSP_TIMEOUT=0. Also drive PSLVERR=1 during SETUP only on a later transfer; expect RSP_ERR=0.
- Hold CMD_VALID high continuously with 4 queued commands. Expect CMD_READY high only in IDLE, 4 transfers spaced 3 cycles apart, and PSELx low for one cycle between them.
- With APB_MASTER_TIMEOUT_EN, TIMEOUT_CYCLES=4 and PREADY stuck low:
  - Expect abort after 4 wait cycles with RSP_ERR=1, RSP_TIMEOUT=1 and RSP_RDATA=0, and PSELx=0 the next cycle.
  - A second run asserts PREADY=1 on the 4th wait cycle; expect normal completion.
- Assert PRESET during an ACCESS wait. Expect PSELx/PENABLE=0 immediately, no RSP_VALID, and CMD_READY=1 after release.
